// File: rtl/ahb_master_burst_engine_if.sv
// Bundle of command, write/read streaming and AHB-Lite bus signals for the
// master burst engine. The master modport is the engine; the slave modport
// is whatever drives commands and models the bus slave.
interface ahb_master_burst_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic                      cmd_write;
    logic [2:0]                cmd_size;
    logic [2:0]                cmd_burst;
    logic                      wdata_valid;
    logic                      wdata_ready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      rdata_valid;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      rdata_last;
    logic                      done;
    logic                      err;
    logic [ADDR_WIDTH-1:0]     haddr;
    logic [1:0]                htrans;
    logic                      hwrite;
    logic [2:0]                hsize;
    logic [2:0]                hburst;
    logic [3:0]                hprot;
    logic [DATA_WIDTH-1:0]     hwdata;
    logic [DATA_WIDTH/8-1:0]   hwstrb;
    logic                      hready;
    logic                      hresp;
    logic [DATA_WIDTH-1:0]     hrdata;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst,
        input  wdata_valid, wdata, hready, hresp, hrdata,
        output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done, err,
        output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hwstrb
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst,
        output wdata_valid, wdata, hready, hresp, hrdata,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done, err,
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hwstrb
    );
endinterface

// File: rtl/ahb_master_burst_engine.sv
// AHB-Lite master burst engine: takes one command per burst, drives the
// pipelined address/data phases, streams write data in through a one-entry
// holding register and read data out, and reports OKAY/ERROR completion.
//
// Handshakes: cmd_valid/cmd_ready and wdata_valid/wdata_ready transfer on a
// rising edge where both are high; valid must not depend on ready. rdata_valid,
// done and err are single-cycle pulses with no backpressure.
module ahb_master_burst_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      hclk,
    input  logic                      hreset,
    ahb_master_burst_engine_if.master bus,
    output logic [1:0]                dbg_state
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int LW = $clog2(SW);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;
    state_t state, state_n;

    // Address-phase registers and burst bookkeeping.
    logic [ADDR_WIDTH-1:0] haddr_q, nxt_addr;
    logic [1:0]            htrans_q;
    logic                  hwrite_q, wrap_q, first_q;
    logic [2:0]            hsize_q, hburst_q;
    logic [4:0]            beats_q, issue_left, fetch_left;
    // Write holding register, data phase tracking and result registers.
    logic                  hold_valid, dp_active, dp_last, dp_write;
    logic [DATA_WIDTH-1:0] hold_data, hwdata_q, rdata_q;
    logic [SW-1:0]         hwstrb_q, strb_c;
    logic                  rdata_valid_q, rdata_last_q, done_q, err_q;

    logic       ap_active, ap_accept, dp_ok, dp_err, err_end, cmd_fire, free;
    logic       wdata_ready_c, take, hold_nv, can_issue, last_accept, done_n;
    logic [4:0] beats_c;
    logic       wrap_c;

    // Next beat address: linear, or wrapped inside the (beats << size) block.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size,
        input logic wrap, input logic [4:0] beats);
        logic [ADDR_WIDTH-1:0] lin, mask;
        lin  = a + (ADDR_WIDTH'(1) << size);
        mask = (ADDR_WIDTH'(beats) << size) - ADDR_WIDTH'(1);
        return wrap ? ((a & ~mask) | (lin & mask)) : lin;
    endfunction

    assign ap_active     = htrans_q[1];                        // NONSEQ or SEQ
    assign ap_accept     = ap_active && bus.hready;
    assign dp_ok         = dp_active && bus.hready && !bus.hresp;
    assign dp_err        = dp_active && bus.hresp && !bus.hready;
    assign err_end       = (state == S_ERR) && dp_active && bus.hresp && bus.hready;
    assign cmd_fire      = (state == S_IDLE) && bus.cmd_valid;
    assign free          = !ap_active || ap_accept;
    assign wdata_ready_c = (state == S_ADDR) && hwrite_q && (fetch_left != 5'd0) &&
                           (!hold_valid || ap_accept);
    assign take          = bus.wdata_valid && wdata_ready_c;
    assign hold_nv       = (hold_valid && !ap_accept) || take;
    assign can_issue     = (state == S_ADDR) && !dp_err && free && (issue_left != 5'd0) &&
                           (!hwrite_q || hold_nv);
    assign last_accept   = (state == S_ADDR) && ap_accept && (issue_left == 5'd0);
    assign done_n        = ((state == S_LAST) && dp_ok && dp_last) || err_end;

    // Decode beat count and wrap mode of the incoming command.
    always_comb begin
        beats_c = 5'd1;
        wrap_c  = 1'b0;
        case (bus.cmd_burst)
            3'b010, 3'b011: beats_c = 5'd4;
            3'b100, 3'b101: beats_c = 5'd8;
            3'b110, 3'b111: beats_c = 5'd16;
            default:        beats_c = 5'd1;
        endcase
        if (bus.cmd_burst == 3'b010 || bus.cmd_burst == 3'b100 || bus.cmd_burst == 3'b110)
            wrap_c = 1'b1;
    end

    // Byte strobes: every lane in the same size-aligned block as haddr.
    always_comb begin
        strb_c = '0;
        for (int i = 0; i < SW; i++)
            if ((i >> hsize_q) == (int'(haddr_q[LW-1:0]) >> hsize_q))
                strb_c[i] = 1'b1;
    end

    // State register.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state logic; an error in a data phase outranks last-address acceptance.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (cmd_fire) state_n = S_ADDR;
            S_ADDR: if (dp_err) state_n = S_ERR;
                    else if (last_accept) state_n = S_LAST;
            S_LAST: if (dp_err) state_n = S_ERR;
                    else if (dp_ok && dp_last) state_n = S_IDLE;
            S_ERR:  if (err_end) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Address phase, write holding register, data phase and result registers.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            haddr_q <= '0; nxt_addr <= '0; htrans_q <= TR_IDLE; hwrite_q <= 1'b0;
            hsize_q <= '0; hburst_q <= '0; wrap_q <= 1'b0; first_q <= 1'b0;
            beats_q <= '0; issue_left <= '0; fetch_left <= '0;
            hold_valid <= 1'b0; hold_data <= '0; hwdata_q <= '0; hwstrb_q <= '0;
            dp_active <= 1'b0; dp_last <= 1'b0; dp_write <= 1'b0;
            rdata_q <= '0; rdata_valid_q <= 1'b0; rdata_last_q <= 1'b0;
            done_q <= 1'b0; err_q <= 1'b0;
        end else begin
            // Address phase: reads put beat 0 on the bus straight from the command.
            if (cmd_fire) begin
                hwrite_q   <= bus.cmd_write;
                hsize_q    <= bus.cmd_size;
                hburst_q   <= (bus.cmd_burst == 3'b001) ? 3'b000 : bus.cmd_burst;
                wrap_q     <= wrap_c;
                beats_q    <= beats_c;
                first_q    <= bus.cmd_write;
                hold_valid <= 1'b0;
                if (bus.cmd_write) begin
                    htrans_q   <= TR_IDLE;
                    nxt_addr   <= bus.cmd_addr;
                    issue_left <= beats_c;
                    fetch_left <= beats_c;
                end else begin
                    htrans_q   <= TR_NONSEQ;
                    haddr_q    <= bus.cmd_addr;
                    nxt_addr   <= next_addr(bus.cmd_addr, bus.cmd_size, wrap_c, beats_c);
                    issue_left <= beats_c - 5'd1;
                    fetch_left <= 5'd0;
                end
            end else begin
                if (dp_err) begin
                    htrans_q <= TR_IDLE;
                end else if (state == S_ADDR && free) begin
                    if (can_issue) begin
                        htrans_q   <= first_q ? TR_NONSEQ : TR_SEQ;
                        haddr_q    <= nxt_addr;
                        nxt_addr   <= next_addr(nxt_addr, hsize_q, wrap_q, beats_q);
                        issue_left <= issue_left - 5'd1;
                        first_q    <= 1'b0;
                    end else if (issue_left != 5'd0 && !first_q) begin
                        htrans_q <= TR_BUSY;
                        haddr_q  <= nxt_addr;
                    end else begin
                        htrans_q <= TR_IDLE;
                    end
                end
                if (take) begin
                    hold_data  <= bus.wdata;
                    hold_valid <= 1'b1;
                    fetch_left <= fetch_left - 5'd1;
                end else if (ap_accept) begin
                    hold_valid <= 1'b0;
                end
            end

            // Data phase opens on address acceptance and closes on hready.
            if (ap_accept) begin
                dp_active <= 1'b1;
                dp_last   <= (issue_left == 5'd0);
                dp_write  <= hwrite_q;
                hwstrb_q  <= strb_c;
                if (hwrite_q) hwdata_q <= hold_data;
            end else if (bus.hready) begin
                dp_active <= 1'b0;
            end

            rdata_valid_q <= dp_ok && !dp_write && (state != S_ERR);
            rdata_last_q  <= dp_ok && !dp_write && (state != S_ERR) && dp_last;
            if (dp_ok && !dp_write) rdata_q <= bus.hrdata;
            done_q <= done_n;
            err_q  <= err_end;
        end
    end

    assign bus.cmd_ready   = (state == S_IDLE);
    assign bus.wdata_ready = wdata_ready_c;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_last  = rdata_last_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.haddr       = haddr_q;
    assign bus.htrans      = htrans_q;
    assign bus.hwrite      = hwrite_q;
    assign bus.hsize       = hsize_q;
    assign bus.hburst      = hburst_q;
    assign bus.hprot       = 4'b0011;
    assign bus.hwdata      = hwdata_q;
    assign bus.hwstrb      = hwstrb_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_ahb_master_burst_engine.sv
// Directed bench for ahb_master_burst_engine: the initial block plays both the
// command sequencer and the AHB slave, cycle by cycle, and checks outputs
// against hand-computed values one time unit after each rising edge.
module tb_ahb_master_burst_engine;
    logic       hclk;
    logic       hreset;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_fail;
    logic [31:0] wd [4];
    logic [31:0] rd [4];
    logic [31:0] wa [4];

    ahb_master_burst_engine_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ahb_master_burst_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [2:0] bt);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_write = w;
        bus.cmd_size  = sz;
        bus.cmd_burst = bt;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wd[0] = 32'h11112222; wd[1] = 32'h33334444; wd[2] = 32'h55556666; wd[3] = 32'h77778888;
        rd[0] = 32'hA0A0A0A0; rd[1] = 32'hB1B1B1B1; rd[2] = 32'hC2C2C2C2; rd[3] = 32'hD3D3D3D3;
        wa[0] = 32'h3038; wa[1] = 32'h303C; wa[2] = 32'h3030; wa[3] = 32'h3034;
        hreset = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_write = 1'b0;
        bus.cmd_size = '0; bus.cmd_burst = '0;
        bus.wdata_valid = 1'b0; bus.wdata = '0;
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;

        // Reset values
        #2 hreset = 1'b1;
        step(); step();
        chk("rst_htrans", bus.htrans, 0);
        chk("rst_haddr", bus.haddr, 0);
        chk("rst_hwrite", bus.hwrite, 0);
        chk("rst_hwstrb", bus.hwstrb, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_wdata_ready", bus.wdata_ready, 0);
        chk("rst_rdata_valid", bus.rdata_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_hprot", bus.hprot, 4'b0011);
        chk("rst_state", dbg_state, 0);
        hreset = 1'b0;
        step();

        // SINGLE read 0x1000, zero wait
        cmd(32'h1000, 1'b0, 3'd2, 3'b000);
        #1 chk("t1_cmd_ready", bus.cmd_ready, 1);
        step(); bus.cmd_valid = 1'b0; #1;
        chk("t1_htrans_nonseq", bus.htrans, 2);
        chk("t1_haddr", bus.haddr, 32'h1000);
        chk("t1_hsize", bus.hsize, 2);
        chk("t1_cmd_ready_busy", bus.cmd_ready, 0);
        step(); bus.hrdata = 32'hCAFEF00D; #1;
        chk("t1_htrans_idle", bus.htrans, 0);
        chk("t1_rvalid_early", bus.rdata_valid, 0);
        step(); #1;
        chk("t1_rvalid", bus.rdata_valid, 1);
        chk("t1_rdata", bus.rdata, 32'hCAFEF00D);
        chk("t1_rlast", bus.rdata_last, 1);
        chk("t1_done", bus.done, 1);
        chk("t1_err", bus.err, 0);
        chk("t1_cmd_ready_back", bus.cmd_ready, 1);
        step(); #1;
        chk("t1_done_pulse", bus.done, 0);

        // INCR4 write 0x2000, data on time
        cmd(32'h2000, 1'b1, 3'd2, 3'b011);
        step(); bus.cmd_valid = 1'b0; bus.wdata_valid = 1'b1; bus.wdata = wd[0]; #1;
        chk("t2_wready_first", bus.wdata_ready, 1);
        chk("t2_htrans_idle_first", bus.htrans, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i < 3) bus.wdata = wd[i+1];
            else       bus.wdata_valid = 1'b0;
            #1;
            chk("t2_htrans", bus.htrans, (i == 0) ? 2 : 3);
            chk("t2_haddr", bus.haddr, 32'h2000 + 4 * i);
            chk("t2_wready", bus.wdata_ready, (i < 3) ? 1 : 0);
            if (i > 0) chk("t2_hwdata", bus.hwdata, wd[i-1]);
        end
        step(); #1;
        chk("t2_htrans_end", bus.htrans, 0);
        chk("t2_hwdata_last", bus.hwdata, wd[3]);
        chk("t2_hwstrb", bus.hwstrb, 4'hF);
        chk("t2_done_early", bus.done, 0);
        step(); #1;
        chk("t2_done", bus.done, 1);
        chk("t2_err", bus.err, 0);

        // WRAP4 read 0x3038
        cmd(32'h3038, 1'b0, 3'd2, 3'b010);
        step(); bus.cmd_valid = 1'b0; #1;
        chk("t3_htrans0", bus.htrans, 2);
        chk("t3_haddr0", bus.haddr, wa[0]);
        for (int i = 1; i <= 4; i++) begin
            step(); bus.hrdata = rd[i-1]; #1;
            if (i < 4) begin
                chk("t3_htrans", bus.htrans, 3);
                chk("t3_haddr", bus.haddr, wa[i]);
            end else begin
                chk("t3_htrans_end", bus.htrans, 0);
            end
            chk("t3_rvalid", bus.rdata_valid, (i >= 2) ? 1 : 0);
            if (i >= 2) begin
                chk("t3_rdata", bus.rdata, rd[i-2]);
                chk("t3_rlast_mid", bus.rdata_last, 0);
            end
        end
        step(); bus.hrdata = '0; #1;
        chk("t3_rvalid_last", bus.rdata_valid, 1);
        chk("t3_rdata_last", bus.rdata, rd[3]);
        chk("t3_rlast", bus.rdata_last, 1);
        chk("t3_done", bus.done, 1);

        // INCR4 write 0x4000 with data late for beat 3
        cmd(32'h4000, 1'b1, 3'd2, 3'b011);
        step(); bus.cmd_valid = 1'b0; bus.wdata_valid = 1'b1; bus.wdata = wd[0]; #1;
        step(); bus.wdata = wd[1]; #1;
        chk("t4_nonseq", bus.htrans, 2);
        chk("t4_haddr0", bus.haddr, 32'h4000);
        step(); bus.wdata_valid = 1'b0; #1;
        chk("t4_seq1", bus.htrans, 3);
        chk("t4_haddr1", bus.haddr, 32'h4004);
        chk("t4_wready_gap", bus.wdata_ready, 1);
        step(); #1;
        chk("t4_busy1", bus.htrans, 1);
        chk("t4_busy1_addr", bus.haddr, 32'h4008);
        chk("t4_hwdata1", bus.hwdata, wd[1]);
        step(); bus.wdata_valid = 1'b1; bus.wdata = wd[2]; #1;
        chk("t4_busy2", bus.htrans, 1);
        chk("t4_busy2_addr", bus.haddr, 32'h4008);
        step(); bus.wdata = wd[3]; #1;
        chk("t4_seq2", bus.htrans, 3);
        chk("t4_haddr2", bus.haddr, 32'h4008);
        step(); bus.wdata_valid = 1'b0; #1;
        chk("t4_haddr3", bus.haddr, 32'h400C);
        chk("t4_hwdata2", bus.hwdata, wd[2]);
        step(); #1;
        chk("t4_hwdata3", bus.hwdata, wd[3]);
        step(); #1;
        chk("t4_done", bus.done, 1);

        // SINGLE byte write 0x4001 with one wait state on the address phase
        cmd(32'h4001, 1'b1, 3'd0, 3'b000);
        step(); bus.cmd_valid = 1'b0; bus.wdata_valid = 1'b1; bus.wdata = 32'h0000AB00; #1;
        chk("t4b_wready", bus.wdata_ready, 1);
        step(); bus.wdata_valid = 1'b0; bus.hready = 1'b0; #1;
        chk("t4b_nonseq", bus.htrans, 2);
        chk("t4b_hsize", bus.hsize, 0);
        step(); bus.hready = 1'b1; #1;
        chk("t4b_nonseq_held", bus.htrans, 2);
        chk("t4b_haddr_held", bus.haddr, 32'h4001);
        step(); #1;
        chk("t4b_hwstrb", bus.hwstrb, 4'b0010);
        chk("t4b_hwdata", bus.hwdata, 32'h0000AB00);
        step(); #1;
        chk("t4b_done", bus.done, 1);

        // INCR8 read 0x5000, ERROR on beat 3
        cmd(32'h5000, 1'b0, 3'd2, 3'b101);
        step(); bus.cmd_valid = 1'b0; #1;
        chk("t5_nonseq", bus.htrans, 2);
        step(); bus.hrdata = rd[0]; #1;
        step(); bus.hrdata = rd[1]; #1;
        chk("t5_rvalid0", bus.rdata_valid, 1);
        chk("t5_rdata0", bus.rdata, rd[0]);
        step(); bus.hready = 1'b0; bus.hresp = 1'b1; bus.hrdata = rd[2]; #1;
        chk("t5_haddr3", bus.haddr, 32'h500C);
        chk("t5_rdata1", bus.rdata, rd[1]);
        step(); bus.hready = 1'b1; #1;
        chk("t5_htrans_idle", bus.htrans, 0);
        chk("t5_rvalid_err", bus.rdata_valid, 0);
        chk("t5_state_err", dbg_state, 3);
        step(); bus.hresp = 1'b0; #1;
        chk("t5_done", bus.done, 1);
        chk("t5_err", bus.err, 1);
        chk("t5_rvalid_none", bus.rdata_valid, 0);
        chk("t5_cmd_ready", bus.cmd_ready, 1);
        step(); #1;
        chk("t5_err_pulse", bus.err, 0);

        // INCR8 write 0x6000, reset while the bus is stalled
        cmd(32'h6000, 1'b1, 3'd2, 3'b101);
        step(); bus.cmd_valid = 1'b0; bus.wdata_valid = 1'b1; bus.wdata = wd[0]; #1;
        step(); bus.wdata = wd[1]; #1;
        step(); bus.hready = 1'b0; #1;
        chk("t6_seq", bus.htrans, 3);
        step(); #1;
        chk("t6_haddr_held", bus.haddr, 32'h6004);
        chk("t6_hwdata", bus.hwdata, wd[0]);
        #2 hreset = 1'b1;
        #1;
        chk("t6_htrans", bus.htrans, 0);
        chk("t6_haddr", bus.haddr, 0);
        chk("t6_hwrite", bus.hwrite, 0);
        chk("t6_hburst", bus.hburst, 0);
        chk("t6_hwdata_rst", bus.hwdata, 0);
        chk("t6_hwstrb", bus.hwstrb, 0);
        chk("t6_cmd_ready", bus.cmd_ready, 1);
        chk("t6_wready", bus.wdata_ready, 0);
        chk("t6_done", bus.done, 0);
        bus.wdata_valid = 1'b0; bus.hready = 1'b1;
        step(); #1;
        chk("t6_done_held", bus.done, 0);
        hreset = 1'b0;
        step(); #1;
        chk("t6_done_after", bus.done, 0);
        chk("t6_htrans_after", bus.htrans, 0);
        chk("t6_state_after", dbg_state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
